// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a downstream 4:1 mux through the enabled channels,
// waits a programmable settle time on each one, and captures mux_y into a
// per-channel result word. Supports single-shot and continuous scanning.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | selects parked at channel a, waiting for an accepted start
//   SETTLE | holding a channel for dwell+1 cycles, capture on the last one
//   DONE   | one cycle presenting the finished result, then idle or rescan
module mux_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [3:0]         en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_y,
    output logic               s1,
    output logic               s2,
    output logic               busy,
    output logic [3:0]         sample,
    output logic               sample_valid,
    output logic               mask_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         ch;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               cont_q;
    logic [3:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         work;

    logic [1:0]         first_in;
    logic [1:0]         first_q;
    logic [1:0]         nxt_ch;
    logic               nxt_valid;
    logic [3:0]         cap_word;
    logic               dwell_hit;

    // Selects come straight from the channel register.
    assign s1 = ch[0];
    assign s2 = ch[1];

    assign dwell_hit = (dwell_cnt == dwell_q);

    // Lowest enabled channel, for the incoming mask and for the latched one.
    always_comb begin
        first_in = 2'd0;
        first_q  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en_mask[i]) first_in = 2'(i);
            if (mask_q[i])  first_q  = 2'(i);
        end
    end

    // Next enabled channel above the current one; disabled channels cost nothing.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_ch    = ch;
        for (int i = 3; i >= 0; i--) begin
            if ((i > int'(ch)) && mask_q[i]) begin
                nxt_valid = 1'b1;
                nxt_ch    = 2'(i);
            end
        end
    end

    // Working word with the current channel's capture merged in, so the final
    // channel's bit lands in sample in the same edge that enters DONE.
    always_comb begin
        cap_word     = work;
        cap_word[ch] = mux_y;
    end

    // Scan sequencer with registered outputs; stop aborts from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= 2'd0;
            dwell_cnt    <= '0;
            cont_q       <= 1'b0;
            mask_q       <= 4'd0;
            dwell_q      <= '0;
            work         <= 4'd0;
            busy         <= 1'b0;
            sample       <= 4'd0;
            sample_valid <= 1'b0;
            mask_err     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            mask_err     <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                ch        <= 2'd0;
                dwell_cnt <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ch   <= 2'd0;
                        busy <= 1'b0;
                        if (start) begin
                            if (en_mask != 4'd0) begin
                                cont_q    <= cont;
                                mask_q    <= en_mask;
                                dwell_q   <= dwell;
                                work      <= 4'd0;
                                ch        <= first_in;
                                dwell_cnt <= '0;
                                busy      <= 1'b1;
                                state     <= SETTLE;
                            end else begin
                                mask_err <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (dwell_hit) begin
                            work      <= cap_word;
                            dwell_cnt <= '0;
                            if (nxt_valid) begin
                                ch <= nxt_ch;
                            end else begin
                                sample       <= cap_word;
                                sample_valid <= 1'b1;
                                state        <= DONE;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end
                    end
                    DONE: begin
                        if (cont_q) begin
                            ch        <= first_q;
                            work      <= 4'd0;
                            dwell_cnt <= '0;
                            state     <= SETTLE;
                        end else begin
                            ch    <= 2'd0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        ch        <= 2'd0;
                        dwell_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
